alien_march_scheduler: RTL
==========================

# alien_march_scheduler

Per-frame motion controller for the alien formation. Once per video frame it scans the alive matrix and finds the surviving extent and population. It then decides whether the formation steps sideways, descends and reverses, or holds. It drives the formation origin and animation phase consumed by the formation renderer, and flags invasion (floor reached) and clearance (no aliens left) to the game state machine.

## Interface
- NUM_ROWS, 5: formation rows; row 0 is the top row.
- NUM_COLUMNS, 8: formation columns; column 0 is the leftmost.
- COL_PITCH, 32: horizontal pixel pitch per column.
- ROW_PITCH, 24: vertical pixel pitch per row.
- START_X, 64 / START_Y, 48: origin after reset.
- STEP_X, 4 / STEP_Y, 8: sideways and descend step sizes, in pixels.
- X_MIN, 8 / X_MAX, 632: inclusive playfield horizontal limits.
- FLOOR_Y, 420: invasion line.
- BASE_DELAY, 8: frames per step when speed-up is compiled out.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- vsync  in  1  frame sync from hvsync_generator, same clock domain.
- run  in  1  high while the game state is playing.
- alive_matrix  in  NUM_ROWS*NUM_COLUMNS  bit r*NUM_COLUMNS+c is alien (r,c).
- formation_x  out  10  origin x of column 0.
- formation_y  out  10  origin y of row 0.
- anim_frame  out  1  sprite phase; toggles on every step.
- step_pulse  out  1  one-cycle pulse when the origin changes.
- invaded  out  1  sticky; formation reached FLOOR_Y.
- cleared  out  1  sticky; alive count reached 0.
- busy  out  1  high during SCAN and DECIDE.

## Operation
- Frame tick: a registered rising edge of vsync, i.e. high for one cycle when vsync is 1 and its previous sample was 0.
- FSM states: IDLE, SCAN, DECIDE.
- IDLE → SCAN: on a frame tick while run=1, invaded=0 and cleared=0. Otherwise the block stays in IDLE and all outputs hold.
- SCAN: visits one column per cycle, c = 0..NUM_COLUMNS-1. Per column it accumulates:
  - leftmost alive column (first column with any alive bit);
  - rightmost alive column (last such column);
  - a row-OR vector, from which bottom = highest alive row index;
  - alive_cnt += popcount of the column.
  - After column NUM_COLUMNS-1 the FSM goes to DECIDE.
- DECIDE (one cycle), evaluated in this order:
  - alive_cnt==0: set cleared and take no step.
  - Otherwise compute fps (frames per step). If frame_cnt+1 < fps: frame_cnt increments. Else frame_cnt clears and a step occurs.
- Step rules:
  - dir=right: edge = formation_x + (rightmost+1)*COL_PITCH. If edge+STEP_X > X_MAX, descend; else formation_x += STEP_X.
  - dir=left: edge = formation_x + leftmost*COL_PITCH. If edge < X_MIN+STEP_X, descend; else formation_x -= STEP_X.
  - Descend: formation_y += STEP_Y, dir flips, formation_x unchanged.
  - Every step toggles anim_frame and pulses step_pulse.
  - After a step, if formation_y + (bottom+1)*ROW_PITCH >= FLOOR_Y, invaded is set.
- Arithmetic: edge computations are 11-bit unsigned, so there is no wrap. alive_cnt width is $clog2(NUM_ROWS*NUM_COLUMNS+1). frame_cnt is 6 bits and saturates at 63.
- Reset values:
  - formation_x=START_X, formation_y=START_Y;
  - dir=right, frame_cnt=0, state IDLE;
  - anim_frame, step_pulse, invaded, cleared, busy all 0.

## Timing
- Frame tick is asserted 1 cycle after vsync rises.
- SCAN lasts NUM_COLUMNS cycles and DECIDE lasts 1 cycle.
- Outputs update and step_pulse asserts NUM_COLUMNS+2 cycles after the tick; busy deasserts in the same cycle.
- alive_matrix column c is sampled only in SCAN cycle c. Mid-scan changes to columns already scanned take effect next frame.
- A frame tick while busy is ignored, with no queuing.
- run falling mid-scan: the scan completes, and DECIDE takes no step and leaves frame_cnt unchanged.
- reset mid-scan: immediate return to the reset values on the next clock edge.
- invaded and cleared clear only on reset.

## Configuration
- MARCH_SPEEDUP_EN defined: fps = (alive_cnt>>1)+1. A full 40-alien formation gives 21 frames per step; a single alien gives 1 frame per step.
- MARCH_SPEEDUP_EN undefined: fps = BASE_DELAY, constant.

## Test plan
- Reset, run=1, full matrix, MARCH_SPEEDUP_EN defined → first step_pulse on the 21st frame tick, NUM_COLUMNS+2 cycles after that tick; formation_x 64→68, anim_frame=1.
- Only column 7 alive, formation_x=568, dir=right → next step descends: formation_y 48→56, formation_x unchanged, dir=left.
- Single alien at row 4: drive steps until formation_y+5*24 ≥ 420 → invaded=1, and no further step_pulse on later ticks.
- All bits 0 at a tick → cleared=1 after DECIDE; formation_x and formation_y unchanged.
- run=0 for 50 frames → busy never asserts, outputs constant. Assert reset during SCAN → all outputs return to reset values on the next cycle.
- MARCH_SPEEDUP_EN undefined, full matrix → step_pulse every 8th frame tick regardless of alive count.

Source files
------------

// File: rtl/alien_march_scheduler.sv
// alien_march_scheduler: once per frame, scans the alive matrix and steps, descends or holds the alien formation.
// Define MARCH_SPEEDUP_EN to make the step rate track the surviving population; otherwise every step takes BASE_DELAY frames.
module alien_march_scheduler #(
  parameter int NUM_ROWS    = 5,
  parameter int NUM_COLUMNS = 8,
  parameter int COL_PITCH   = 32,
  parameter int ROW_PITCH   = 24,
  parameter int START_X     = 64,
  parameter int START_Y     = 48,
  parameter int STEP_X      = 4,
  parameter int STEP_Y      = 8,
  parameter int X_MIN       = 8,
  parameter int X_MAX       = 632,
  parameter int FLOOR_Y     = 420,
  parameter int BASE_DELAY  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vsync,
  input  logic                            run,
  input  logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_matrix,
  output logic [9:0]                      formation_x,
  output logic [9:0]                      formation_y,
  output logic                            anim_frame,
  output logic                            step_pulse,
  output logic                            invaded,
  output logic                            cleared,
  output logic                            busy
);
  localparam int CW = NUM_COLUMNS > 1 ? $clog2(NUM_COLUMNS) : 1;
  localparam int RW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;
  localparam int AW = $clog2(NUM_ROWS*NUM_COLUMNS+1);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

  state_t              state_q, state_d;
  logic                vsync_q, tick_q;
  logic [CW-1:0]       col_q, col_d, left_q, left_d, right_q, right_d;
  logic                found_q, found_d;
  logic [NUM_ROWS-1:0] rows_q, rows_d, col_bits;
  logic [AW-1:0]       cnt_q, cnt_d, col_pop;
  logic [5:0]          frame_q, frame_d;
  logic                dir_left_q, dir_left_d;
  logic [9:0]          x_q, x_d, y_q, y_d, y_next;
  logic                anim_q, anim_d, pulse_q, pulse_d, inv_q, inv_d, clr_q, clr_d;
  logic [RW-1:0]       bottom;
  logic [6:0]          fps;
  logic [10:0]         edge_r, edge_l;
  logic                go_down, floor_hit;

  always_comb begin
    col_bits = '0;
    col_pop  = '0;
    bottom   = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLUMNS; c++)
        if (CW'(c) == col_q) col_bits[r] = alive_matrix[r*NUM_COLUMNS+c];
      col_pop = col_pop + AW'(col_bits[r]);
      if (rows_q[r]) bottom = RW'(r);
    end
  end

`ifdef MARCH_SPEEDUP_EN
  assign fps = 7'(cnt_q >> 1) + 7'd1;
`else
  assign fps = 7'(BASE_DELAY);
`endif

  // 11-bit edges keep the playfield comparisons free of wrap-around
  assign edge_r    = 11'(x_q) + 11'((int'(right_q) + 1) * COL_PITCH);
  assign edge_l    = 11'(x_q) + 11'(int'(left_q) * COL_PITCH);
  assign go_down   = dir_left_q ? (edge_l < 11'(X_MIN + STEP_X)) : (edge_r + 11'(STEP_X) > 11'(X_MAX));
  assign y_next    = go_down ? y_q + 10'(STEP_Y) : y_q;
  assign floor_hit = 11'(y_next) + 11'((int'(bottom) + 1) * ROW_PITCH) >= 11'(FLOOR_Y);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    left_d     = left_q;
    right_d    = right_q;
    found_d    = found_q;
    rows_d     = rows_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    dir_left_d = dir_left_q;
    x_d        = x_q;
    y_d        = y_q;
    anim_d     = anim_q;
    pulse_d    = 1'b0;
    inv_d      = inv_q;
    clr_d      = clr_q;
    case (state_q)
      IDLE: if (tick_q && run && !inv_q && !clr_q) begin
        state_d = SCAN;
        col_d   = '0;
        left_d  = '0;
        right_d = '0;
        found_d = 1'b0;
        rows_d  = '0;
        cnt_d   = '0;
      end
      SCAN: begin
        left_d  = (|col_bits && !found_q) ? col_q : left_q;
        right_d = |col_bits ? col_q : right_q;
        found_d = found_q | (|col_bits);
        rows_d  = rows_q | col_bits;
        cnt_d   = cnt_q + col_pop;
        col_d   = col_q + CW'(1);
        state_d = (col_q == CW'(NUM_COLUMNS - 1)) ? DECIDE : SCAN;
      end
      DECIDE: begin
        state_d = IDLE;
        if (run) begin
          if (cnt_q == '0) clr_d = 1'b1;
          else if ({1'b0, frame_q} + 7'd1 < fps) frame_d = (frame_q == 6'd63) ? frame_q : frame_q + 6'd1;
          else begin
            frame_d    = '0;
            pulse_d    = 1'b1;
            anim_d     = ~anim_q;
            y_d        = y_next;
            dir_left_d = go_down ? ~dir_left_q : dir_left_q;
            x_d        = go_down ? x_q : (dir_left_q ? x_q - 10'(STEP_X) : x_q + 10'(STEP_X));
            inv_d      = inv_q | floor_hit;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vsync_q    <= 1'b0;
      tick_q     <= 1'b0;
      col_q      <= '0;
      left_q     <= '0;
      right_q    <= '0;
      found_q    <= 1'b0;
      rows_q     <= '0;
      cnt_q      <= '0;
      frame_q    <= '0;
      dir_left_q <= 1'b0;
      x_q        <= 10'(START_X);
      y_q        <= 10'(START_Y);
      anim_q     <= 1'b0;
      pulse_q    <= 1'b0;
      inv_q      <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync;
      tick_q     <= vsync & ~vsync_q;
      col_q      <= col_d;
      left_q     <= left_d;
      right_q    <= right_d;
      found_q    <= found_d;
      rows_q     <= rows_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      dir_left_q <= dir_left_d;
      x_q        <= x_d;
      y_q        <= y_d;
      anim_q     <= anim_d;
      pulse_q    <= pulse_d;
      inv_q      <= inv_d;
      clr_q      <= clr_d;
    end
  end

  assign formation_x = x_q;
  assign formation_y = y_q;
  assign anim_frame  = anim_q;
  assign step_pulse  = pulse_q;
  assign invaded     = inv_q;
  assign cleared     = clr_q;
  assign busy        = state_q != IDLE;
endmodule
